multiplier_seq: RTL and testbench

Parametrised sequential shift-add multiplier: the multi-cycle successor to the 2-bit combinational multiplier. It multiplies two WIDTH-bit operands, either unsigned or two's-complement signed, one partial product per clock, and returns a 2·WIDTH-bit product. A start/busy/done handshake makes it usable from datapath controllers that issue one multiply at a time. Area scales linearly with WIDTH rather than quadratically.

---
 rtl/multiplier_seq_pkg.sv | 21 ++
 rtl/multiplier_seq_negate.sv | 21 ++
 rtl/multiplier_seq.sv | 138 +++++++++++++
 tb/tb_multiplier_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_seq_pkg
// Description : Shared definitions for the sequential shift-add multiplier:
//               operand width ceiling and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package multiplier_seq_pkg;

    // Widest operand the multiplier is built for.
    localparam int WIDTH_MAX = 32;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multiplier_seq_negate.sv
`default_nettype none
// ============================================================================
// Module      : negate_2w
// Description : Combinational two's-complement negate of a W-bit value.
//               Used at 2*WIDTH for the final product sign and at WIDTH for
//               the operand magnitudes.
// Ports       : i_value - value to negate
//               o_value - (-i_value) modulo 2^W
// Revision    : 1.0 - initial release
// ============================================================================
module negate_2w #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_value
);

    assign o_value = (~i_value) + {{(W-1){1'b0}}, 1'b1};

endmodule
`default_nettype wire

// File: rtl/multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_seq
// Description : Sequential shift-add multiplier, unsigned or two's-complement
//               signed, one partial product per clock. Operates on operand
//               magnitudes and applies the sign in a final step.
// Ports       : clk         - clock, rising edge
//               rst         - synchronous active-high reset
//               start       - request, sampled only while idle
//               signed_mode - 1 = signed operands, latched on accepted start
//               a, b        - multiplicand / multiplier, latched on start
//               busy        - operation in progress
//               done        - one-cycle pulse when p is updated
//               p           - 2*WIDTH product, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("multiplier_seq: WIDTH out of range");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     w_a_neg;
    logic [WIDTH-1:0]     w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_acc_neg;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_p;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_neg;
    logic                 r_done;

    negate_2w #(.W(WIDTH)) u_neg_a (
        .i_value (a),
        .o_value (w_a_neg)
    );

    negate_2w #(.W(WIDTH)) u_neg_b (
        .i_value (b),
        .o_value (w_b_neg)
    );

    negate_2w #(.W(2*WIDTH)) u_neg_acc (
        .i_value (r_acc),
        .o_value (w_acc_neg)
    );

    // Negating -2^(W-1) yields 2^(W-1), which is the correct unsigned
    // magnitude, so WIDTH-bit magnitudes never overflow.
    assign w_a_mag = (signed_mode && a[WIDTH-1]) ? w_a_neg : a;
    assign w_b_mag = (signed_mode && b[WIDTH-1]) ? w_b_neg : b;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_CALC;
            // Leave after the WIDTH-th partial product.
            ST_CALC: if (r_count == c_CNT_W'(1)) w_state_next = ST_SIGN;
            ST_SIGN: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_p      <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= c_CNT_W'(WIDTH);
                    end
                end
                ST_CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - c_CNT_W'(1);
                end
                ST_SIGN: begin
                    r_p    <= r_neg ? w_acc_neg : r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_seq
// Description : Self-checking bench for multiplier_seq. Instances at WIDTH
//               2, 3, 4, 8 and 16 share clock, reset and operand buses; each
//               has its own start line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_seq;

    logic        clk;
    logic        rst;
    logic        sm;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [4:0]  start_v;
    logic [4:0]  busy_v;
    logic [4:0]  done_v;
    logic [3:0]  p2;
    logic [5:0]  p3;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [31:0] p16;

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm),
        .a(a_in[1:0]), .b(b_in[1:0]), .busy(busy_v[0]), .done(done_v[0]), .p(p2));
    multiplier_seq #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm),
        .a(a_in[2:0]), .b(b_in[2:0]), .busy(busy_v[1]), .done(done_v[1]), .p(p3));
    multiplier_seq #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm),
        .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy_v[2]), .done(done_v[2]), .p(p4));
    multiplier_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[3]), .signed_mode(sm),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy_v[3]), .done(done_v[3]), .p(p8));
    multiplier_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(start_v[4]), .signed_mode(sm),
        .a(a_in[15:0]), .b(b_in[15:0]), .busy(busy_v[4]), .done(done_v[4]), .p(p16));

    function automatic int idx_of(input int w);
        case (w)
            2:       return 0;
            3:       return 1;
            4:       return 2;
            8:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [63:0] p_of(input int w);
        case (w)
            2:       return 64'(p2);
            3:       return 64'(p3);
            4:       return 64'(p4);
            8:       return 64'(p8);
            default: return 64'(p16);
        endcase
    endfunction

    // Behavioural reference: plain integer multiply, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av,
                                            input logic [31:0] bv, input logic s);
        longint sa;
        longint sb;
        longint prod;
        longint mask;
        mask = (longint'(1) << w) - 1;
        sa = longint'(av) & mask;
        sb = longint'(bv) & mask;
        if (s && sa[w-1]) sa = sa - (longint'(1) << w);
        if (s && sb[w-1]) sb = sb - (longint'(1) << w);
        prod = sa * sb;
        return 64'(prod & ((longint'(1) << (2*w)) - 1));
    endfunction

    // Call at a negedge. Returns the product and the number of cycles from
    // the start edge to the cycle in which done is seen (-1 on timeout).
    task automatic do_mul(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic smv, output logic [63:0] pv, output int lat);
        int i;
        i = idx_of(w);
        a_in = av;
        b_in = bv;
        sm   = smv;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        lat = 0;
        while (done_v[i] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        pv = p_of(w);
        if (lat >= 40) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_v = '0;
        sm = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0)
                $display("FAIL reset_flags inst %0d busy=%b done=%b want 0/0", k, busy_v[k], done_v[k]);
            else n_pass++;
        end
        n_checks++;
        if ({p2, p3, p4, p8, p16} !== '0)
            $display("FAIL reset_p p2=%h p4=%h p8=%h p16=%h want 0", p2, p4, p8, p16);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_w2_legacy;
        logic [31:0] va [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
        logic [31:0] vb [4] = '{32'd0, 32'd2, 32'd3, 32'd3};
        logic [63:0] ve [4] = '{64'd0, 64'd2, 64'd6, 64'd9};
        logic [63:0] pv;
        int lat;
        for (int k = 0; k < 4; k++) begin
            do_mul(2, va[k], vb[k], 1'b0, pv, lat);
            n_checks++;
            if (pv !== ve[k]) $display("FAIL w2_p %0d*%0d got %0d want %0d", va[k], vb[k], pv, ve[k]);
            else n_pass++;
            n_checks++;
            if (lat != 3) $display("FAIL w2_latency got %0d want 3", lat);
            else n_pass++;
        end
    endtask

    task automatic test_w8_corners;
        logic [31:0] va [4] = '{32'hFF, 32'h80, 32'h80, 32'hFF};
        logic [31:0] vb [4] = '{32'hFF, 32'h80, 32'h7F, 32'h01};
        logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] ve [4] = '{64'hFE01, 64'h4000, 64'hC080, 64'hFFFF};
        logic [63:0] pv;
        int lat;
        for (int k = 0; k < 4; k++) begin
            do_mul(8, va[k], vb[k], vs[k], pv, lat);
            n_checks++;
            if (pv !== ve[k] || lat != 9)
                $display("FAIL w8_corner %h*%h s=%b got %h lat %0d want %h lat 9",
                         va[k][7:0], vb[k][7:0], vs[k], pv, lat, ve[k]);
            else n_pass++;
        end
    endtask

    task automatic test_busy_restart;
        int ndone;
        logic [7:0] pv;
        logic busy0;
        ndone = 0;
        pv = '0;
        busy0 = 1'b0;
        a_in = 32'd3;
        b_in = 32'd5;
        sm = 1'b0;
        start_v[2] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0) begin
                busy0 = busy_v[2];
                a_in = 32'd2;
                b_in = 32'd2;
            end
            if (k == 4) start_v[2] = 1'b0;
            if (done_v[2] === 1'b1) begin
                ndone++;
                pv = p4;
            end
        end
        n_checks++;
        if (busy0 !== 1'b1) $display("FAIL restart_busy got %b want 1", busy0);
        else n_pass++;
        n_checks++;
        if (ndone != 1) $display("FAIL restart_done_count got %0d want 1", ndone);
        else n_pass++;
        n_checks++;
        if (pv !== 8'd15) $display("FAIL restart_p got %0d want 15", pv);
        else n_pass++;
        n_checks++;
        if (busy_v[2] !== 1'b0) $display("FAIL restart_idle busy=%b want 0", busy_v[2]);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] pv;
        int lat;
        do_mul(4, 32'd3, 32'd5, 1'b0, pv, lat);
        n_checks++;
        if (pv !== 64'd15 || lat != 5) $display("FAIL b2b_first got %0d lat %0d want 15 lat 5", pv, lat);
        else n_pass++;
        do_mul(4, 32'd7, 32'd7, 1'b0, pv, lat);
        n_checks++;
        if (pv !== 64'd49 || lat != 5) $display("FAIL b2b_second got %0d lat %0d want 49 lat 5", pv, lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int ndone;
        ndone = 0;
        a_in = 32'd100;
        b_in = 32'd3;
        sm = 1'b0;
        start_v[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start_v[3] = 1'b0;
            if (k == 3) rst = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (busy_v[3] !== 1'b0 || done_v[3] !== 1'b0 || p8 !== 16'h0)
            $display("FAIL reset_mid busy=%b done=%b p=%h want 0/0/0000", busy_v[3], done_v[3], p8);
        else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_v[3] === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0) $display("FAIL reset_mid_no_done got %0d dones want 0", ndone);
        else n_pass++;
    endtask

    task automatic test_operand_change;
        int lat;
        logic [15:0] pmid;
        a_in = 32'd6;
        b_in = 32'd7;
        sm = 1'b0;
        start_v[3] = 1'b1;
        @(negedge clk);
        start_v[3] = 1'b0;
        a_in = 32'd0;
        b_in = 32'd0;
        sm = 1'b1;
        repeat (3) @(negedge clk);
        pmid = p8;
        sm = 1'b0;
        lat = 3;
        while (done_v[3] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (pmid !== 16'h0) $display("FAIL opchg_p_mid got %h want 0000", pmid);
        else n_pass++;
        n_checks++;
        if (p8 !== 16'd42 || lat != 9) $display("FAIL opchg_p got %0d lat %0d want 42 lat 9", p8, lat);
        else n_pass++;
    endtask

    task automatic test_random;
        int widths [3] = '{3, 8, 16};
        logic [63:0] pv;
        logic [63:0] exp_p;
        logic [31:0] ra;
        logic [31:0] rb;
        int lat;
        for (int wi = 0; wi < 3; wi++) begin
            for (int m = 0; m < 2; m++) begin
                for (int n = 0; n < 150; n++) begin
                    ra = $urandom;
                    rb = $urandom;
                    exp_p = ref_mul(widths[wi], ra, rb, m[0]);
                    do_mul(widths[wi], ra, rb, m[0], pv, lat);
                    n_checks++;
                    if (pv !== exp_p || lat != widths[wi] + 1)
                        $display("FAIL rand_w%0d s=%0d a=%h b=%h got %h lat %0d want %h",
                                 widths[wi], m, ra, rb, pv, lat, exp_p);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst = 1'b1;
        start_v = '0;
        test_reset;
        test_w2_legacy;
        test_w8_corners;
        test_busy_restart;
        test_back_to_back;
        test_reset_mid;
        test_operand_change;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
